// File: rtl/mhsa_pkg.sv
// Shared types and default sizes for the bar SRAM responder.
package mhsa_pkg;

    localparam int BAR_WIDTH  = 64;
    localparam int BAR_LENGTH = 4096;

    typedef enum logic {
        BAR_CLEAR = 1'b0,
        BAR_IDLE  = 1'b1
    } bar_state_e;

endpackage

// File: rtl/bar_rd_pipe.sv
// RD_LAT-deep delay line for read data and the out-of-range flag.
// The final stage updates data_out only when a read slot arrives.
module bar_rd_pipe #(
    parameter int WIDTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_vld,
    input  logic             rd_oor,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] data_out,
    output logic             oor_err
);

    typedef struct packed {
        logic             vld;
        logic             oor;
        logic [WIDTH-1:0] data;
    } slot_t;

    slot_t head;
    slot_t tail;

    assign head = '{vld: rd_vld, oor: rd_oor, data: rd_data};

    if (RD_LAT == 1) begin : g_direct
        assign tail = head;
    end else begin : g_line
        slot_t [RD_LAT-2:0] line;

        // NOTE: sequential state uses non-blocking assignments so every stage
        // shifts from the values present before the edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                line <= '0;
            end else begin
                line[0] <= head;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    line[i] <= line[i-1];
                end
            end
        end

        assign tail = line[RD_LAT-2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            oor_err  <= 1'b0;
        end else begin
            oor_err <= tail.oor;
            if (tail.vld) begin
                data_out <= tail.data;
            end
        end
    end

endmodule

// File: rtl/bar_sram_resp.sv
// Single-port SRAM bar responder with zero-fill clear and pipelined reads.
// Optional access counters rd_cnt/wr_cnt are enabled by BAR_SRAM_STAT_EN.
module bar_sram_resp
    import mhsa_pkg::*;
#(
    parameter int          WIDTH  = BAR_WIDTH,
    parameter int          LENGTH = BAR_LENGTH,
    parameter logic [31:0] BASE   = 32'h0,
    parameter int          RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic [31:0]      addr,
    output logic [WIDTH-1:0] data_out,
    input  logic             clear_req,
    output logic             clear_busy,
    output logic             oor_err
`ifdef BAR_SRAM_STAT_EN
    ,
    output logic [31:0]      rd_cnt,
    output logic [31:0]      wr_cnt
`endif
);

    localparam int             IDX_W    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    bar_state_e       state;
    bar_state_e       state_next;
    logic [IDX_W-1:0] clr_idx;
    logic [WIDTH-1:0] mem [LENGTH];

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             idle;
    logic [WIDTH-1:0] rd_data;

    assign offset   = addr - BASE;
    assign in_range = (addr >= BASE) && (offset < 32'(LENGTH));
    assign idx      = offset[IDX_W-1:0];
    assign idle     = (state == BAR_IDLE);
    assign rd_data  = (idle && in_range) ? mem[idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BAR_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment ahead of the case keeps this block free of
    // inferred latches on paths that do not change state.
    always_comb begin
        state_next = state;
        case (state)
            BAR_CLEAR: if (clr_idx == LAST_IDX) state_next = BAR_IDLE;
            BAR_IDLE:  if (clear_req)           state_next = BAR_CLEAR;
            default:                            state_next = BAR_CLEAR;
        endcase
    end

    always_comb begin
        clear_busy = (state == BAR_CLEAR);
    end

    // The clear index parks on the last word instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_idx <= '0;
        end else if (state == BAR_CLEAR) begin
            if (clr_idx != LAST_IDX) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end else begin
            clr_idx <= '0;
        end
    end

    // NOTE: the array is deliberately left out of reset; the zero-fill that
    // follows every reset is what initialises it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == BAR_CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (in_range && write_en) begin
                mem[idx] <= data_in;
            end
        end
    end

    bar_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_vld   (!write_en),
        .rd_oor   (idle && !in_range),
        .rd_data  (rd_data),
        .data_out (data_out),
        .oor_err  (oor_err)
    );

`ifdef BAR_SRAM_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (idle && clear_req) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (idle && in_range) begin
            if (write_en && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (!write_en && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/bar_sram_resp.md
BAR_SRAM_RESP -- requirements
Module: bar_sram_resp

Interface
REQ-001 Parameter WIDTH, default 64, data word width in bits.
REQ-002 Parameter LENGTH, default 4096, number of words held.
REQ-003 Parameter BASE, default 32'h0, first word address decoded by this bar.
REQ-004 Parameter RD_LAT, default 1, read latency in cycles, legal range 1..4.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 write_en  input  1  1 = write the addressed word, 0 = read it.
REQ-008 data_in  input  WIDTH  write data.
REQ-009 addr  input  32  word address, sampled every cycle.
REQ-010 data_out  output  WIDTH  read data.
REQ-011 clear_req  input  1  request a zero-fill of the whole array.
REQ-012 clear_busy  output  1  high while a zero-fill is in progress.
REQ-013 oor_err  output  1  one-cycle pulse flagging an out-of-range access.

Function
REQ-014 Single-port responder: every cycle is exactly one access, a read (write_en=0) or a write (write_en=1).
REQ-015 In range means BASE <= addr and (addr-BASE) < LENGTH; the word index is addr-BASE.
REQ-016 In-range write in IDLE: data_in is stored at the index on that clock edge; data_out is not updated.
REQ-017 In-range read in IDLE: the stored word appears on data_out exactly RD_LAT cycles after the access cycle, then holds until the next read result.
REQ-018 Read-after-write: a read of an address written in the previous cycle returns the new data.
REQ-019 Out-of-range write: dropped, array unchanged.
REQ-020 Out-of-range read: data_out = 0 after RD_LAT cycles.
REQ-021 oor_err pulses high for one cycle, aligned with the RD_LAT-delayed slot of any out-of-range access, read or write.
REQ-022 FSM states: CLEAR and IDLE.
REQ-023 CLEAR state: write zero to one word per cycle at index 0..LENGTH-1, then go to IDLE.
  - A clear takes exactly LENGTH cycles.
  - clear_busy = 1 for exactly those cycles.
REQ-024 IDLE -> CLEAR when clear_req = 1; clear_req is ignored while in CLEAR.
REQ-025 Initiator accesses during CLEAR:
  - writes are dropped;
  - reads return 0 after RD_LAT cycles;
  - oor_err is not asserted.
REQ-026 The clear index counter is $clog2(LENGTH) bits and does not wrap; the final index LENGTH-1 ends the clear.
REQ-027 The read pipeline keeps flowing across CLEAR->IDLE and IDLE->CLEAR transitions; every access produces its result slot exactly RD_LAT cycles later.

Reset
REQ-028 Asserting rst_n low forces:
  - data_out = 0, oor_err = 0;
  - read pipeline emptied;
  - FSM = CLEAR, clear index = 0.
REQ-029 After rst_n rises, the automatic clear runs: clear_busy = 1 from the first edge until LENGTH cycles later.
REQ-030 Reset asserted mid-clear or mid-read abandons the operation; the array contents are not reset, only overwritten by the subsequent clear.

Configuration
REQ-031 Macro BAR_SRAM_STAT_EN, when defined, adds:
  - outputs rd_cnt (32) and wr_cnt (32), counting accepted in-range reads and writes in IDLE;
  - both counters saturate at 32'hFFFF_FFFF;
  - both counters are zeroed by reset and when a clear starts.
REQ-032 Without BAR_SRAM_STAT_EN, rd_cnt and wr_cnt and their logic are absent; all other behaviour is identical.

Structure
REQ-033 Package mhsa_pkg holds:
  - the bar FSM state enum (BAR_CLEAR, BAR_IDLE);
  - the default constants BAR_WIDTH = 64 and BAR_LENGTH = 4096.
REQ-034 Sub-module bar_rd_pipe carries the read data and oor flag through an RD_LAT-deep delay line, with the reset behaviour of REQ-028.

Verification
REQ-035 Reset release, LENGTH=16: clear_busy high exactly 16 cycles; any read afterwards returns 0.
REQ-036 IDLE, RD_LAT=1: write 64'hDEAD_BEEF_0123_4567 @ addr BASE+5, read BASE+5 next cycle -> data_out = that value 1 cycle later.
REQ-037 RD_LAT=3, back-to-back reads of indices 0,1,2 holding 10,11,12 -> data_out = 10,11,12 on cycles 3,4,5.
REQ-038 Write to BASE+LENGTH -> oor_err single pulse, array unchanged; read of BASE-1 -> data_out = 0 with oor_err pulse.
REQ-039 clear_req in IDLE after writes: writes issued during clear_busy are dropped; all words read 0 afterwards; clear_req during CLEAR does not extend clear_busy.
REQ-040 With BAR_SRAM_STAT_EN: 3 writes and 2 reads in range plus 1 out-of-range -> wr_cnt = 3, rd_cnt = 2; clear_req -> both 0.
